uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- Serialises one byte per request onto an asynchronous UART line in 8N1 format: 1 start bit, 8 data bits LSB-first, 1 stop bit.
- Timing comes from a system clock, nominally 50 MHz driving a 115200 baud line.
- Sits between a byte-producing core and the board TX pin.
- Reports frame completion with a single-cycle done pulse.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency.
- BAUD_RATE, 115200, line bit rate.
- CLKS_PER_BIT, CLK_FREQ_HZ/BAUD_RATE (integer division, 434 by default), clock cycles per bit. Local, derived; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- data_in  input  8  byte to send; sampled only when a start is accepted.
- start_transmit  input  1  request strobe; level sampled each clk edge.
- tx  output  1  serial line; idle/mark = 1.
- transmission_done  output  1  one-cycle pulse at end of stop bit.

Behaviour:
- Reset (reset=0, async):
  - FSM goes to IDLE; tx=1, transmission_done=0.
  - Bit counter, baud counter and shift register are cleared.
  - Reset mid-frame aborts the frame; tx returns to 1 immediately, without waiting for clk.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
- IDLE:
  - tx=1.
  - On a clk edge with start_transmit=1: latch data_in into the shift register, clear the baud counter, go to START.
  - tx falls on that same edge, so latency from the sampling edge to the start bit is 0 cycles.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - tx = shift_reg[index], each bit held CLKS_PER_BIT cycles, index 0..7 (LSB first).
  - After bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- transmission_done:
  - High for exactly one cycle, on the edge where STOP completes and the FSM enters IDLE.
  - Otherwise 0.
- Frame length: 10*CLKS_PER_BIT cycles (4340 cycles = 86.8 us at defaults).
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary. Width is clog2(CLKS_PER_BIT).
- start_transmit while not in IDLE is ignored; no queuing.
- Changes on data_in after acceptance have no effect on the frame in flight.
- Back-to-back frames:
  - start_transmit sampled in the cycle after done (first IDLE cycle) begins the next frame.
  - Minimum gap is 1 idle cycle of tx=1 beyond the stop bit.
- start_transmit held high continuously: a new frame starts on every IDLE cycle, giving a continuous stream with a 1-cycle idle between frames.
- All outputs registered; no combinational path from inputs to tx or transmission_done.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 8 latched data bits (even parity), held for CLKS_PER_BIT cycles.
  - Frame becomes 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, 8N1 exactly as above.

Test Plan:
- Reset check: reset=0 for 100 ns -> tx=1, transmission_done=0. Assert reset=0 mid-DATA -> tx=1 and FSM in IDLE with no clk edge required.
- Single frame at defaults: data_in=8'hAA, start_transmit pulsed for 1 clk (20 ns) -> tx levels per 8680 ns slot are 0, 0,1,0,1,0,1,0,1, 1. transmission_done pulses once, 4340 cycles after acceptance. Receiver sampling mid-bit recovers 8'hAA.
- Busy rejection: start a frame with 8'h55, pulse start_transmit with data_in=8'hFF during the DATA state -> line carries only 8'h55. Exactly one done pulse; tx=1 after the stop bit.
- Back-to-back: hold start_transmit=1 with data_in=8'h00 then 8'hFF -> two frames, separated by exactly 1 idle cycle after the first stop bit. Two done pulses, 4341 cycles apart.
- Data change after accept: accept 8'h0F, change data_in to 8'hF0 one cycle later -> line carries 8'h0F.
- With UART_TX_PARITY_EN, data_in=8'h07 -> parity bit=1. With data_in=8'h03 -> parity bit=0. Frame is 4774 cycles.

Source files
------------

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: one byte per accepted start strobe, LSB first, registered outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_transmitter #(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned BAUD_RATE   = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       start_transmit,
    output logic       tx,
    output logic       transmission_done
);

    // Must come out >= 2 for the bit-boundary compare to be meaningful.
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e          state_q;
    logic [CntW-1:0] baud_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            tx_q;
    logic            done_q;
    logic            bit_end;

    assign bit_end = (baud_q == LastCnt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != StIdle) begin
                baud_q <= bit_end ? '0 : baud_q + 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    // tx drops on the accepting edge: zero-cycle start latency.
                    if (start_transmit) begin
                        shift_q   <= data_in;
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b0;
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        tx_q      <= shift_q[0];
                        bit_idx_q <= '0;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= ^shift_q;
                            state_q <= StParity;
`else
                            tx_q    <= 1'b1;
                            state_q <= StStop;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[bit_idx_q + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        tx_q    <= 1'b1;
                        state_q <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (bit_end) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign tx                = tx_q;
    assign transmission_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: table-driven frames, random frames with busy pokes,
// and hand-written reset sequences, all compared against a slot-based line model.
module tb_uart_transmitter;

    localparam int N = 50000000 / 115200;
`ifdef UART_TX_PARITY_EN
    localparam int NSLOT = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int NSLOT = 10;
    localparam bit PAR   = 1'b0;
`endif
    localparam int FL = NSLOT * N;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_transmit = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx;
    logic       transmission_done;

    int checks = 0;
    int failures = 0;

    bit         line_a[$];
    bit         done_a[$];
    int         f_off[2];
    logic [7:0] f_byte[2];
    int         nfr;

    typedef struct {
        string      name;
        logic [7:0] d0;
        bit         hold;
        int         p_at;
        bit         p_start;
        logic [7:0] p_data;
        int         rel_at;
        int         nfr;
        logic [7:0] d1;
    } vec_t;

    vec_t vecs[4];

    uart_transmitter dut (
        .clk               (clk),
        .reset             (reset),
        .data_in           (data_in),
        .start_transmit    (start_transmit),
        .tx                (tx),
        .transmission_done (transmission_done)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Line level at cycle k given the frames accepted at f_off[] carrying f_byte[].
    function automatic bit exp_tx(input int k);
        for (int f = 0; f < nfr; f++) begin
            if (k >= f_off[f] && k < f_off[f] + FL) begin
                int s;
                s = (k - f_off[f]) / N;
                if (s == 0) return 1'b0;
                if (s <= 8) return f_byte[f][s-1];
                if (s == 9 && PAR) return ^f_byte[f];
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic bit in_frame(input int k);
        for (int f = 0; f < nfr; f++) begin
            if (k >= f_off[f] && k < f_off[f] + FL) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit exp_done(input int k);
        for (int f = 0; f < nfr; f++) begin
            if (k == f_off[f] + FL) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic run_vec(input vec_t v);
        int len;
        int bad;
        int ndone;
        logic [7:0] rx;
        nfr       = v.nfr;
        f_off[0]  = 0;
        f_byte[0] = v.d0;
        f_off[1]  = FL + 1;
        f_byte[1] = v.d1;
        len = (v.nfr == 2) ? 2 * FL + 6 : FL + 4;
        line_a.delete();
        done_a.delete();
        @(negedge clk);
        data_in        = v.d0;
        start_transmit = 1'b1;
        // Index i is sampled on the negedge after the accepting posedge plus i cycles.
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            line_a.push_back(tx);
            done_a.push_back(transmission_done);
            if (i == 0 && !v.hold) start_transmit = 1'b0;
            if (i == v.p_at) begin
                start_transmit = v.p_start;
                data_in        = v.p_data;
            end
            if (i == v.rel_at) start_transmit = 1'b0;
        end
        start_transmit = 1'b0;

        for (int f = 0; f < nfr; f++) begin
            for (int s = 0; s < NSLOT; s++) begin
                bad = 0;
                for (int c = 0; c < N; c++) begin
                    int k;
                    k = f_off[f] + s * N + c;
                    if (line_a[k] != exp_tx(k)) bad++;
                end
                chk($sformatf("%s frame%0d slot%0d wrong cycles", v.name, f, s), bad, 0);
            end
            rx = 8'h00;
            for (int b = 0; b < 8; b++) rx[b] = line_a[f_off[f] + (b + 1) * N + N / 2];
            chk($sformatf("%s frame%0d received byte", v.name, f), rx, f_byte[f]);
            chk($sformatf("%s frame%0d done at end of stop", v.name, f),
                done_a[f_off[f] + FL], 1);
        end
        bad   = 0;
        ndone = 0;
        for (int k = 0; k < len; k++) begin
            if (!in_frame(k) && line_a[k] != 1'b1) bad++;
            if (done_a[k] != exp_done(k)) bad++;
            if (done_a[k]) ndone++;
        end
        chk($sformatf("%s idle/done wrong cycles", v.name), bad, 0);
        chk($sformatf("%s done pulse count", v.name), ndone, v.nfr);
    endtask

    initial begin
        vec_t rv;
        vecs[0] = '{"aa",    8'hAA, 1'b0, -1,     1'b0, 8'h00, -1,         1, 8'h00};
        vecs[1] = '{"busy",  8'h55, 1'b0, 3 * N,  1'b1, 8'hFF, 3 * N + 1,  1, 8'h00};
        vecs[2] = '{"dchg",  8'h0F, 1'b0, 0,      1'b0, 8'hF0, -1,         1, 8'h00};
        vecs[3] = '{"b2b",   8'h00, 1'b1, 0,      1'b1, 8'hFF, FL + 5,     2, 8'hFF};

        // Reset held without any dependence on the clock.
        #100;
        chk("reset tx", tx, 1);
        chk("reset done", transmission_done, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle tx after reset", tx, 1);

        // Reset in the middle of the data bits returns the line high at once.
        data_in        = 8'hC3;
        start_transmit = 1'b1;
        @(negedge clk);
        start_transmit = 1'b0;
        repeat (3 * N) @(negedge clk);
        chk("tx low before mid-frame reset", tx, 0);
        #5;
        reset = 1'b0;
        #1;
        chk("mid-frame async reset tx", tx, 1);
        chk("mid-frame async reset done", transmission_done, 0);
        @(posedge clk);
        #1;
        chk("tx held high in reset", tx, 1);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        for (int r = 0; r < 3; r++) begin
            rv.name    = $sformatf("rand%0d", r);
            rv.d0      = 8'($urandom);
            rv.hold    = 1'b0;
            rv.p_at    = $urandom_range(1, FL - 1);
            rv.p_start = 1'b1;
            rv.p_data  = 8'($urandom);
            rv.rel_at  = rv.p_at + 1;
            rv.nfr     = 1;
            rv.d1      = 8'h00;
            run_vec(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
